// File: rtl/can_fd_rx_field_sequencer_if.sv
// Sampled-bit stream from the bit-timing/destuff datapath into the receive field sequencer.
// bit_valid_i is a one-cycle strobe per sample point; bit_i and stuff_bit_i are meaningful only
// while it is high. error_i is an independent pulse. There is no ready: the sequencer never stalls the stream.
interface can_fd_rx_field_sequencer_if;
  logic bit_valid_i;
  logic bit_i;
  logic stuff_bit_i;
  logic error_i;

  modport master (output bit_valid_i, output bit_i, output stuff_bit_i, output error_i);
  modport slave  (input  bit_valid_i, input  bit_i, input  stuff_bit_i, input  error_i);
endinterface

// File: rtl/can_fd_rx_field_sequencer.sv
// CAN / CAN FD receive frame sequencer: walks frame fields on destuffed sample points,
// latches frame attributes, derives data/CRC lengths and drives the data-phase bit-rate switch.
module can_fd_rx_field_sequencer #(
  parameter bit FD_ENABLE      = 1'b1,
  parameter int MAX_DATA_BYTES = 64,
  parameter int INTEG_BITS     = 11,
  localparam int CNT_W         = $clog2(MAX_DATA_BYTES*8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reset_mode_i,
  can_fd_rx_field_sequencer_if.slave rx_if,
  output logic [4:0]            state_o,
  output logic [CNT_W-1:0]      field_cnt_o,
  output logic                  frame_ext_o,
  output logic                  frame_rtr_o,
  output logic                  frame_fd_o,
  output logic                  brs_o,
  output logic                  esi_o,
  output logic [3:0]            dlc_o,
  output logic [6:0]            data_bytes_o,
  output logic [4:0]            crc_len_o,
  output logic                  data_phase_o,
  output logic                  frame_done_o
);

  typedef enum logic [4:0] {
    S_OFF = 5'd0, S_INTEG = 5'd1, S_IDLE = 5'd2, S_ID1 = 5'd3, S_RTR1 = 5'd4,
    S_IDE = 5'd5, S_ID2 = 5'd6, S_RTR2 = 5'd7, S_FDF = 5'd8, S_R0 = 5'd9,
    S_RES = 5'd10, S_BRS = 5'd11, S_ESI = 5'd12, S_DLC = 5'd13, S_DATA = 5'd14,
    S_STUFF_CNT = 5'd15, S_CRC = 5'd16, S_CRC_LIM = 5'd17, S_ACK = 5'd18,
    S_ACK_LIM = 5'd19, S_EOF = 5'd20, S_INTER = 5'd21, S_ERROR = 5'd22,
    S_OVERLOAD = 5'd23, S_SKIP_FDF = 5'd24
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_q, ext_d, rtr_q, rtr_d, fd_q, fd_d;
  logic             brs_q, brs_d, esi_q, esi_d;
  logic [3:0]       dlc_q, dlc_d;
  logic [6:0]       bytes_q, bytes_d;
  logic [4:0]       crc_len_q, crc_len_d;
  logic             dphase_q, dphase_d;
  logic             done_q, done_d;

  function automatic logic [6:0] decode_bytes(input logic [3:0] dlc, input logic rtr,
                                              input logic fd);
    logic [6:0] v;
    v = {3'b000, dlc};
    if (rtr) begin
      v = 7'd0;
    end else if (!fd) begin
      if (dlc > 4'd8) v = 7'd8;
    end else begin
      case (dlc)
        4'd9:    v = 7'd12;
        4'd10:   v = 7'd16;
        4'd11:   v = 7'd20;
        4'd12:   v = 7'd24;
        4'd13:   v = 7'd32;
        4'd14:   v = 7'd48;
        4'd15:   v = 7'd64;
        default: v = {3'b000, dlc};
      endcase
      if (v > 7'(MAX_DATA_BYTES)) v = 7'(MAX_DATA_BYTES);
    end
    return v;
  endfunction

  logic             in_stuff_range;
  logic             ev;
  logic             rx;
  logic [CNT_W-1:0] cnt_inc;
  logic [9:0]       cnt_ext;
  logic [9:0]       data_last;
  logic [9:0]       crc_last;
  logic [3:0]       dlc_full;
  logic [6:0]       bytes_dec;
  logic             err_allowed;

  // Stuff bits only exist between SOF and the end of the CRC sequence.
  assign in_stuff_range = (state_q >= S_ID1) && (state_q <= S_CRC);
  assign ev        = rx_if.bit_valid_i && !(rx_if.stuff_bit_i && in_stuff_range);
  assign rx        = rx_if.bit_i;
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_ext   = 10'(cnt_q);
  assign data_last = {bytes_q, 3'b000} - 10'd1;
  assign crc_last  = 10'(crc_len_q) - 10'd1;
  assign dlc_full  = {dlc_q[2:0], rx};
  assign bytes_dec = decode_bytes(dlc_full, rtr_q, fd_q);
  assign err_allowed = (state_q != S_OFF) && (state_q != S_INTEG) &&
                       (state_q != S_ERROR) && (state_q != S_SKIP_FDF);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    rtr_d     = rtr_q;
    fd_d      = fd_q;
    brs_d     = brs_q;
    esi_d     = esi_q;
    dlc_d     = dlc_q;
    bytes_d   = bytes_q;
    crc_len_d = crc_len_q;
    dphase_d  = dphase_q;
    done_d    = 1'b0;

    if (reset_mode_i) begin
      state_d  = S_OFF;
      dphase_d = 1'b0;
    end else if (rx_if.error_i && err_allowed) begin
      state_d  = S_ERROR;
      dphase_d = 1'b0;
    end else if (state_q == S_OFF) begin
      state_d = S_INTEG;
    end else if (ev) begin
      case (state_q)
        S_INTEG, S_SKIP_FDF: begin
          if (!rx)                               cnt_d   = '0;
          else if (cnt_ext == 10'(INTEG_BITS-1)) state_d = S_IDLE;
          else                                   cnt_d   = cnt_inc;
        end
        S_IDLE, S_INTER: begin
          if (state_q == S_INTER && !rx && cnt_ext < 10'd2) begin
            state_d = S_OVERLOAD;
          end else if (!rx) begin
            // Start of frame: previous frame's attributes no longer apply.
            state_d   = S_ID1;
            ext_d     = 1'b0;
            rtr_d     = 1'b0;
            fd_d      = 1'b0;
            brs_d     = 1'b0;
            esi_d     = 1'b0;
            dlc_d     = 4'd0;
            bytes_d   = 7'd0;
            crc_len_d = 5'd0;
            dphase_d  = 1'b0;
          end else if (state_q == S_INTER && cnt_ext == 10'd2) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ID1:  if (cnt_ext == 10'd10) state_d = S_RTR1; else cnt_d = cnt_inc;
        S_RTR1: begin rtr_d = rx; state_d = S_IDE; end
        S_IDE: begin
          if (rx) begin
            ext_d   = 1'b1;
            state_d = S_ID2;
          end else begin
            state_d = S_FDF;
          end
        end
        S_ID2:  if (cnt_ext == 10'd17) state_d = S_RTR2; else cnt_d = cnt_inc;
        S_RTR2: begin rtr_d = rx; state_d = S_FDF; end
        S_FDF: begin
          if (!rx) begin
            state_d = S_R0;
          end else if (FD_ENABLE) begin
            fd_d    = 1'b1;
            rtr_d   = 1'b0;
            state_d = S_RES;
          end else begin
            state_d = S_SKIP_FDF;
          end
        end
        S_R0:  state_d = S_DLC;
        S_RES: state_d = S_BRS;
        S_BRS: begin brs_d = rx; dphase_d = rx; state_d = S_ESI; end
        S_ESI: begin esi_d = rx; state_d = S_DLC; end
        S_DLC: begin
          dlc_d = dlc_full;
          if (cnt_ext == 10'd3) begin
            bytes_d   = bytes_dec;
            crc_len_d = !fd_q ? 5'd15 : (bytes_dec <= 7'd16 ? 5'd17 : 5'd21);
            if (bytes_dec != 7'd0) state_d = S_DATA;
            else                   state_d = fd_q ? S_STUFF_CNT : S_CRC;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DATA: begin
          if (cnt_ext == data_last) state_d = fd_q ? S_STUFF_CNT : S_CRC;
          else                      cnt_d   = cnt_inc;
        end
        S_STUFF_CNT: if (cnt_ext == 10'd3) state_d = S_CRC; else cnt_d = cnt_inc;
        S_CRC:       if (cnt_ext == crc_last) state_d = S_CRC_LIM; else cnt_d = cnt_inc;
        S_CRC_LIM:   begin dphase_d = 1'b0; state_d = S_ACK; end
        S_ACK: begin
          // FD receivers tolerate a two-bit ACK slot; a recessive second bit is the delimiter.
          if (!fd_q)                state_d = S_ACK_LIM;
          else if (cnt_ext == 10'd0) cnt_d  = cnt_inc;
          else                      state_d = rx ? S_EOF : S_ACK_LIM;
        end
        S_ACK_LIM: state_d = S_EOF;
        S_EOF: begin
          if (cnt_ext == 10'd6) begin
            state_d = rx ? S_INTER : S_OVERLOAD;
          end else begin
            if (cnt_ext == 10'd5) done_d = 1'b1;
            cnt_d = cnt_inc;
          end
        end
        S_ERROR, S_OVERLOAD: begin
          if (!rx)                     cnt_d   = '0;
          else if (cnt_ext == 10'd7)   state_d = S_INTER;
          else                         cnt_d   = cnt_inc;
        end
        default: state_d = S_OFF;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      ext_q     <= 1'b0;
      rtr_q     <= 1'b0;
      fd_q      <= 1'b0;
      brs_q     <= 1'b0;
      esi_q     <= 1'b0;
      dlc_q     <= 4'd0;
      bytes_q   <= 7'd0;
      crc_len_q <= 5'd0;
      dphase_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      rtr_q     <= rtr_d;
      fd_q      <= fd_d;
      brs_q     <= brs_d;
      esi_q     <= esi_d;
      dlc_q     <= dlc_d;
      bytes_q   <= bytes_d;
      crc_len_q <= crc_len_d;
      dphase_q  <= dphase_d;
      done_q    <= done_d;
    end
  end

  assign state_o      = state_q;
  assign field_cnt_o  = cnt_q;
  assign frame_ext_o  = ext_q;
  assign frame_rtr_o  = rtr_q;
  assign frame_fd_o   = fd_q;
  assign brs_o        = brs_q;
  assign esi_o        = esi_q;
  assign dlc_o        = dlc_q;
  assign data_bytes_o = bytes_q;
  assign crc_len_o    = crc_len_q;
  assign data_phase_o = dphase_q;
  assign frame_done_o = done_q;

endmodule
